// File: rtl/alu_cc_stage.sv
// alu_cc_stage: one-deep registered ALU result stage with Y86 condition codes and Cnd evaluation.
// Define ALU_CC_FWD_EN to evaluate Cnd from the flags being written by the same Set_CC transfer.
module alu_cc_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [63:0] ALU_Out,
  input  logic        Overflow,
  input  logic [3:0]  ifun,
  input  logic        Set_CC,
  input  logic [3:0]  cond_fn,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [63:0] Val_E,
  output logic        Cnd,
  output logic        ZF,
  output logic        SF,
  output logic        OF
);
  logic        out_valid_q, out_valid_d;
  logic [63:0] val_q, val_d;
  logic        cnd_q, cnd_d;
  logic        zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic        xfer, new_zf, new_sf, new_of, cz, cs, co, cnd_calc;
  assign In_ready  = !out_valid_q || Out_ready;
  assign Out_valid = out_valid_q;
  assign Val_E     = val_q;
  assign Cnd       = cnd_q;
  assign ZF        = zf_q;
  assign SF        = sf_q;
  assign OF        = of_q;
  always_comb begin
    xfer   = In_valid && In_ready;
    new_zf = ALU_Out == 64'd0;
    new_sf = ALU_Out[63];
    new_of = (ifun == 4'd0 || ifun == 4'd1) && Overflow;
`ifdef ALU_CC_FWD_EN
    cz = Set_CC ? new_zf : zf_q;
    cs = Set_CC ? new_sf : sf_q;
    co = Set_CC ? new_of : of_q;
`else
    cz = zf_q;
    cs = sf_q;
    co = of_q;
`endif
    cnd_calc = 1'b0;
    case (cond_fn)
      4'd0: cnd_calc = 1'b1;
      4'd1: cnd_calc = (cs ^ co) | cz;
      4'd2: cnd_calc = cs ^ co;
      4'd3: cnd_calc = cz;
      4'd4: cnd_calc = !cz;
      4'd5: cnd_calc = !(cs ^ co);
      4'd6: cnd_calc = !(cs ^ co) && !cz;
      default: cnd_calc = 1'b0;
    endcase
    out_valid_d = xfer ? 1'b1 : (Out_ready ? 1'b0 : out_valid_q);
    val_d       = xfer ? ALU_Out : val_q;
    cnd_d       = xfer ? cnd_calc : cnd_q;
    zf_d        = (xfer && Set_CC) ? new_zf : zf_q;
    sf_d        = (xfer && Set_CC) ? new_sf : sf_q;
    of_d        = (xfer && Set_CC) ? new_of : of_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      val_q       <= 64'd0;
      cnd_q       <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      val_q       <= val_d;
      cnd_q       <= cnd_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
    end
  end
endmodule

// File: doc/alu_cc_stage.md
ALU_CC_STAGE -- requirements
Module: alu_cc_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port In_valid, input, 1, ALU result presented this cycle.
REQ-004 SHALL have port In_ready, output, 1, stage can accept a result this cycle.
REQ-005 SHALL have port ALU_Out, input, 64, ALU result (add/sub/and/xor output).
REQ-006 SHALL have port Overflow, input, 1, ALU signed-overflow flag for ALU_Out.
REQ-007 SHALL have port ifun, input, 4, ALU op code: 0 add, 1 sub, 2 and, 3 xor; 4..15 reserved.
REQ-008 SHALL have port Set_CC, input, 1, update condition codes on this transfer.
REQ-009 SHALL have port cond_fn, input, 4, Y86 condition selector for Cnd.
REQ-010 SHALL have port Out_valid, output, 1, registered result held.
REQ-011 SHALL have port Out_ready, input, 1, downstream accepts held result.
REQ-012 SHALL have port Val_E, output, 64, registered ALU result.
REQ-013 SHALL have port Cnd, output, 1, registered condition outcome.
REQ-014 SHALL have ports ZF, SF, OF, output, 1 each, current condition-code register.

Function
REQ-015 SHALL transfer in when In_valid && In_ready; In_ready = !Out_valid || Out_ready (combinational).
REQ-016 SHALL have latency 1: transferred ALU_Out appears on Val_E with Out_valid=1 the following cycle.
REQ-017 SHALL implement two states via Out_valid: EMPTY (0) and FULL (1); EMPTY->FULL on transfer; FULL->EMPTY on Out_ready with no transfer; FULL->FULL on simultaneous Out_ready and transfer (new data replaces old, no bubble).
REQ-018 SHALL hold Val_E, Cnd stable while Out_valid && !Out_ready.
REQ-019 SHALL, on transfer with Set_CC=1, load ZF = (ALU_Out==0), SF = ALU_Out[63], OF = Overflow if ifun in {0,1}, else 0.
REQ-020 SHALL leave ZF/SF/OF unchanged when Set_CC=0 or no transfer occurs.
REQ-021 SHALL treat ifun 4..15 as and/xor for OF purposes (OF=0).
REQ-022 SHALL compute Cnd at transfer from flags selected per REQ-030/031: cond_fn 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7..15 Cnd=0.
REQ-023 SHALL ignore In_valid while In_ready=0; upstream holds inputs stable until transfer.
REQ-024 SHALL pass ALU_Out unmodified to Val_E (no width change, no sign handling).

Reset
REQ-025 SHALL, on rst assertion, immediately set Out_valid=0, Val_E=0, Cnd=0, ZF=1, SF=0, OF=0.
REQ-026 SHALL discard any held result on reset mid-operation; no transfer completes in a cycle where rst is high.
REQ-027 SHALL drive In_ready=1 during and after reset (EMPTY state).
REQ-028 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL use macro ALU_CC_FWD_EN to select Cnd flag source.
REQ-030 SHALL, with ALU_CC_FWD_EN defined, evaluate Cnd on a Set_CC=1 transfer from the newly computed flags of that same transfer.
REQ-031 SHALL, without ALU_CC_FWD_EN, always evaluate Cnd from the flag register value before the transfer's update.

Verification
REQ-032 SHALL cover: reset then transfer ALU_Out=0, ifun=3, Set_CC=1, cond_fn=3 -> next cycle Val_E=0, ZF=1, SF=0, OF=0, Cnd=1 (ZF=1 both builds).
REQ-033 SHALL cover: transfer ALU_Out=64'h8000_0000_0000_0000, Overflow=1, ifun=0, Set_CC=1 -> ZF=0, SF=1, OF=1; then cond_fn=2, Set_CC=0 transfer -> Cnd=0 (SF^OF=0).
REQ-034 SHALL cover: Overflow=1, ifun=2, Set_CC=1 -> OF=0.
REQ-035 SHALL cover: Out_ready=0 for 3 cycles while FULL with In_valid=1 -> In_ready=0, Val_E unchanged, CC unchanged; Out_ready=1 -> In_ready=1, pending result transfers, Out_valid stays 1.
REQ-036 SHALL cover: from reset flags, transfer ALU_Out=5, ifun=0, Set_CC=1, cond_fn=4 -> Cnd=1 with ALU_CC_FWD_EN, Cnd=0 without.
REQ-037 SHALL cover: rst asserted asynchronously mid-cycle while FULL with Val_E=64'hDEAD -> Out_valid=0, Val_E=0, ZF=1 before next clock edge.
